// File: rtl/mul_iter_param.sv
// Parametrised iterative multiplier: retires STEP multiplier bits per cycle
// on magnitudes and applies the sign at the end. It has an optional early
// exit once the remaining multiplier bits are zero, and it holds its result
// while start_i stays high.
module mul_iter_param #(
    parameter int WIDTH     = 32,
    parameter int STEP      = 1,
    parameter int EARLY_OUT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               cancel_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CW     = $clog2(NSTEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mb;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;
    logic               r_neg;
    logic               r_busy;
    logic               r_ready;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH-1:0]   w_maIn;
    logic [WIDTH-1:0]   w_mbIn;
    logic               w_negIn;
    logic               w_zeroIn;
    logic [2*WIDTH-1:0] w_partial;
    logic [WIDTH-1:0]   w_mbNext;
    logic               w_exitRun;
    logic [2*WIDTH-1:0] w_fixResult;

    // Operand magnitudes and the product sign at accept time; the most
    // negative value keeps its own bit pattern, which is its unsigned magnitude
    always_comb begin
        w_maIn   = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
        w_mbIn   = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;
        w_negIn  = signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
        w_zeroIn = (opa_i == '0) || (opb_i == '0);
    end

    // Shift-add partial product for the STEP low multiplier bits of this cycle
    always_comb begin
        w_partial = '0;
        for (int j = 0; j < STEP; j++) begin
            if (r_mb[j]) begin
                w_partial = w_partial + (r_mcand << j);
            end
        end
    end

    // Leave RUN on the last chunk, or earlier when nothing is left to add
    always_comb begin
        w_mbNext    = r_mb >> STEP;
        w_exitRun   = (r_count == CW'(NSTEPS - 1)) ||
                      ((EARLY_OUT != 0) && (w_mbNext == '0));
        w_fixResult = r_neg ? -r_acc : r_acc;
    end

    // Control FSM with registered outputs; cancel aborts from any active state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && !cancel_i) begin
                        r_neg   <= w_negIn;
                        r_mcand <= {{WIDTH{1'b0}}, w_maIn};
                        r_mb    <= w_mbIn;
                        r_acc   <= '0;
                        r_count <= '0;
                        if (w_zeroIn) begin
                            r_state  <= S_DONE;
                            r_ready  <= 1'b1;
                            r_result <= '0;
                            r_busy   <= 1'b0;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (cancel_i) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end else begin
                        r_acc   <= r_acc + w_partial;
                        r_mcand <= r_mcand << STEP;
                        r_mb    <= w_mbNext;
                        r_count <= r_count + 1'b1;
                        if (w_exitRun) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (cancel_i) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end else begin
                        r_state  <= S_DONE;
                        r_result <= w_fixResult;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (cancel_i || !start_i) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_ready  <= 1'b0;
                    r_result <= '0;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign ready_o  = r_ready;
    assign result_o = r_result;

endmodule

// File: tb/tb_mul_iter_param.sv
// Scoreboard bench for mul_iter_param: a default-configuration instance
// driven with directed vectors, plus a 16-bit/STEP=4 pair (early-out on and
// off) driven with a directed-then-random sweep against a reference product.
module tb_mul_iter_param;

    typedef struct {
        logic [63:0] res;
        int          edgeNo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          nVec = 0;
    int          nMis = 0;

    logic        startA, cancelA, signedA;
    logic [31:0] opaA, opbA;
    logic        busyA, readyA;
    logic [63:0] resA;

    logic        startC, startD, cancelW, signedW;
    logic [15:0] opaW, opbW;
    logic        busyC, readyC, busyD, readyD;
    logic [31:0] resC, resD;

    exp_t        qA[$];
    exp_t        qC[$];
    exp_t        qD[$];
    logic        prevA = 1'b0;
    logic        prevC = 1'b0;
    logic        prevD = 1'b0;

    mul_iter_param u_dutA (
        .clk(clk), .rst(rst), .start_i(startA), .cancel_i(cancelA),
        .signed_i(signedA), .opa_i(opaA), .opb_i(opbA),
        .busy_o(busyA), .ready_o(readyA), .result_o(resA)
    );

    mul_iter_param #(.WIDTH(16), .STEP(4), .EARLY_OUT(1)) u_dutC (
        .clk(clk), .rst(rst), .start_i(startC), .cancel_i(cancelW),
        .signed_i(signedW), .opa_i(opaW), .opb_i(opbW),
        .busy_o(busyC), .ready_o(readyC), .result_o(resC)
    );

    mul_iter_param #(.WIDTH(16), .STEP(4), .EARLY_OUT(0)) u_dutD (
        .clk(clk), .rst(rst), .start_i(startD), .cancel_i(cancelW),
        .signed_i(signedW), .opa_i(opaW), .opb_i(opbW),
        .busy_o(busyD), .ready_o(readyD), .result_o(resD)
    );

    // Free-running clock and edge counter used to time-stamp ready
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Every comparison goes through here so the counters stay in one place
    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        nVec++;
        if (got !== want) begin
            nMis++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Reference product, truncated to 2*w bits
    function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input int w);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        p = 64'(sa * sb);
        if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    // Edges from accept to the edge after which ready is first seen
    function automatic int expLatency(input logic [31:0] a, input logic [31:0] b,
                                      input logic s, input int w, input int step, input int eo);
        logic [31:0] mask;
        logic [31:0] mb;
        int          k;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (((a & mask) == 0) || ((b & mask) == 0)) return 0;
        mb = (s && b[w-1]) ? ((~b + 32'd1) & mask) : (b & mask);
        k = 0;
        for (int i = 0; i < w; i++) if (mb[i]) k = i;
        if (eo != 0) return (k + step) / step + 1;
        return w / step + 1;
    endfunction

    // Monitor for the default instance
    always @(negedge clk) begin
        exp_t e;
        if (rst && readyA && !prevA) begin
            if (qA.size() == 0) begin
                checkOutput("unexpected readyA", 64'(readyA), 64'd0);
            end else begin
                e = qA.pop_front();
                checkOutput("resultA", resA, e.res);
                checkOutput("latencyA", 64'(cyc), 64'(e.edgeNo));
            end
        end
        prevA = readyA;
    end

    // Monitor for the early-out 16-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (rst && readyC && !prevC) begin
            if (qC.size() == 0) begin
                checkOutput("unexpected readyC", 64'(readyC), 64'd0);
            end else begin
                e = qC.pop_front();
                checkOutput("resultC", {32'd0, resC}, e.res);
                checkOutput("latencyC", 64'(cyc), 64'(e.edgeNo));
            end
        end
        prevC = readyC;
    end

    // Monitor for the fixed-latency 16-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (rst && readyD && !prevD) begin
            if (qD.size() == 0) begin
                checkOutput("unexpected readyD", 64'(readyD), 64'd0);
            end else begin
                e = qD.pop_front();
                checkOutput("resultD", {32'd0, resD}, e.res);
                checkOutput("latencyD", 64'(cyc), 64'(e.edgeNo));
            end
        end
        prevD = readyD;
    end

    // One full transaction on the default instance; operands are scrambled
    // right after accept, and the result is held for 'hold' cycles before release
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input logic [63:0] expRes, input int expLat, input int hold);
        exp_t e;
        int   n;
        bit   seen;
        bit   busyOk;
        @(negedge clk);
        opaA = a; opbA = b; signedA = s; startA = 1'b1;
        e.res = expRes;
        e.edgeNo = cyc + 1 + expLat;
        qA.push_back(e);
        @(posedge clk);
        @(negedge clk);
        opaA = ~a; opbA = b ^ 32'h5A5A_0F0F; signedA = ~s;
        seen = 1'b0; busyOk = 1'b1; n = 0;
        while (!seen && n < 200) begin
            if (readyA) begin
                seen = 1'b1;
            end else begin
                if (busyA !== 1'b1) busyOk = 1'b0;
                @(negedge clk);
                n++;
            end
        end
        checkOutput("readyA within bound", 64'(seen), 64'd1);
        checkOutput("busyA window", 64'(busyOk && (busyA === 1'b0)), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("held readyA", 64'(readyA), 64'd1);
            checkOutput("held resultA", resA, expRes);
        end
        startA = 1'b0;
        @(negedge clk);
        checkOutput("released readyA", 64'(readyA), 64'd0);
        checkOutput("released resultA", resA, 64'd0);
    endtask

    // One transaction issued to both 16-bit instances at the same edge
    task automatic applyStimulusPair(input logic [15:0] a, input logic [15:0] b, input logic s);
        exp_t ec;
        exp_t ed;
        int   n;
        bit   doneC;
        bit   doneD;
        @(negedge clk);
        opaW = a; opbW = b; signedW = s; startC = 1'b1; startD = 1'b1;
        ec.res = refMul({16'd0, a}, {16'd0, b}, s, 16);
        ed.res = ec.res;
        ec.edgeNo = cyc + 1 + expLatency({16'd0, a}, {16'd0, b}, s, 16, 4, 1);
        ed.edgeNo = cyc + 1 + expLatency({16'd0, a}, {16'd0, b}, s, 16, 4, 0);
        qC.push_back(ec);
        qD.push_back(ed);
        @(posedge clk);
        @(negedge clk);
        opaW = ~a; opbW = ~b; signedW = ~s;
        doneC = 1'b0; doneD = 1'b0; n = 0;
        while (!(doneC && doneD) && n < 100) begin
            if (readyC) begin doneC = 1'b1; startC = 1'b0; end
            if (readyD) begin doneD = 1'b1; startD = 1'b0; end
            @(negedge clk);
            n++;
        end
        if (!(doneC && doneD)) begin
            checkOutput("pair completion", {62'd0, doneC, doneD}, 64'd3);
            startC = 1'b0;
            startD = 1'b0;
        end
    endtask

    // Main directed sequence followed by the 16-bit sweep
    initial begin
        rst = 1'b0;
        startA = 1'b0; cancelA = 1'b0; signedA = 1'b0; opaA = '0; opbA = '0;
        startC = 1'b0; startD = 1'b0; cancelW = 1'b0; signedW = 1'b0; opaW = '0; opbW = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset readyA", 64'(readyA), 64'd0);
        checkOutput("reset busyA", 64'(busyA), 64'd0);
        checkOutput("reset resultA", resA, 64'd0);
        checkOutput("reset 16-bit outputs", {28'd0, busyC, readyC, busyD, readyD, resC | resD}, 64'd0);
        rst = 1'b1;

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 33, 0);
        applyStimulus(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 4, 0);
        applyStimulus(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 3, 0);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, 2, 0);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 64'h0000_0000_8000_0000, 2, 0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 33, 0);
        applyStimulus(32'h0000_0000, 32'h0000_1234, 1'b0, 64'h0, 0, 0);
        applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0, 64'd15, 3, 5);
        applyStimulus(32'h0000_1234, 32'h00FF_0000, 1'b0, 64'h0000_0012_21CC_0000, 25, 0);

        // Cancel at RUN edge 10 while start is still high
        @(negedge clk);
        opaA = 32'hFFFF_FFFF; opbA = 32'hFFFF_FFFF; signedA = 1'b0; startA = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("busyA before cancel", 64'(busyA), 64'd1);
        cancelA = 1'b1;
        @(negedge clk);
        cancelA = 1'b0;
        startA = 1'b0;
        checkOutput("cancel readyA", 64'(readyA), 64'd0);
        checkOutput("cancel busyA", 64'(busyA), 64'd0);
        checkOutput("cancel resultA", resA, 64'd0);
        applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0, 64'd15, 3, 0);

        // Reset in the middle of RUN
        @(negedge clk);
        opaA = 32'h1234_5678; opbA = 32'h8765_4321; signedA = 1'b1; startA = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid-run reset outputs", {busyA, readyA, resA[61:0]}, 64'd0);
        startA = 1'b0;
        rst = 1'b1;
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3, 0);

        // 16-bit STEP=4 sweep, corner pairs first
        applyStimulusPair(16'h0000, 16'h0005, 1'b0);
        applyStimulusPair(16'h8000, 16'h8000, 1'b1);
        applyStimulusPair(16'hFFFF, 16'hFFFF, 1'b0);
        applyStimulusPair(16'hFFFF, 16'hFFFF, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            applyStimulusPair(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        checkOutput("pending A", 64'(qA.size()), 64'd0);
        checkOutput("pending C", 64'(qC.size()), 64'd0);
        checkOutput("pending D", 64'(qD.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mul_iter_param.md
# mul_iter_param

Parametrised iterative multiplier, successor to the fixed 32-bit shift-add unit in the execute stage. Consumes STEP multiplier bits per cycle, trading area for latency. Supports signed and unsigned operands and latches them at accept. Adds cancel, early-out on zero/short multipliers and a busy indication. Sits beside the divider under the EX-stage stall controller, using the same start/ready hold handshake.

## Interface
- WIDTH, 32, operand width; ≥2; result is 2·WIDTH.
- STEP, 1, multiplier bits retired per RUN cycle; one of 1, 2, 4; WIDTH % STEP == 0.
- EARLY_OUT, 1, 1 = leave RUN once remaining multiplier bits are all zero; 0 = fixed latency.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-low.
- start_i  in  1  request; sampled in IDLE; must stay high until result consumed.
- cancel_i  in  1  abort current operation.
- signed_i  in  1  1 = two's-complement operands; latched at accept.
- opa_i  in  WIDTH  multiplicand; latched at accept.
- opb_i  in  WIDTH  multiplier; latched at accept.
- busy_o  out  1  high in RUN and FIX.
- ready_o  out  1  result valid.
- result_o  out  2·WIDTH  product; 0 when not ready.

## Operation
- Reset (rst=0 at edge): state IDLE, ready_o=0, result_o=0, busy_o=0, internal registers cleared.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start_i=1 and cancel_i=0 (accept):
  - latch signed_i.
  - ma = |opa_i|, mb = |opb_i| (negate only when signed_i=1 and MSB=1). 0x80..0 magnitude is 0x80..0 as unsigned.
  - neg = signed_i & (opa_i[W-1] ^ opb_i[W-1]).
  - acc = 0; count = 0.
  - If opa_i==0 or opb_i==0: go DONE with result_o=0, ready_o=1. Otherwise go RUN.
- RUN, per cycle:
  - acc += (mcand · mb[STEP-1:0]), truncated to 2W; mcand is a 2W register starting at {0,ma}.
  - mcand <<= STEP; mb >>= STEP; count++.
  - Go FIX when count reaches WIDTH/STEP−1 at this edge, or when EARLY_OUT=1 and shifted mb == 0.
- FIX: result_o = neg ? −acc : acc (2W two's complement); ready_o=1; go DONE.
- DONE:
  - hold result_o and ready_o while start_i=1.
  - start_i=0: go IDLE; ready_o=0 and result_o=0 at that edge.
- cancel_i=1 in RUN, FIX or DONE: go IDLE next edge with ready_o=0, result_o=0, busy_o=0. No result is produced. cancel_i beats start_i when both are high.
- cancel_i=1 in IDLE blocks accept.
- Operand and signed_i changes after accept are ignored.

## Timing
- Accept edge = edge 0.
- Zero operand: ready_o=1 after edge 0.
- EARLY_OUT=0: RUN occupies edges 1..N, N = WIDTH/STEP; FIX at edge N+1; ready_o=1 after edge N+1. Default config: after edge 33.
- EARLY_OUT=1: k = index of highest set bit of mb. RUN cycles R = ceil((k+1)/STEP); ready_o=1 after edge R+1.
- busy_o high from after edge 0 until the edge entering DONE.
- After start_i drops in DONE, the next accept is possible one edge later (IDLE must be observed).
- Reset mid-operation: IDLE at that edge; all outputs zero.

## Test plan
- Unsigned, EARLY_OUT=0, default widths: 0xFFFFFFFF × 0xFFFFFFFF -> result_o=0xFFFFFFFE00000001, ready_o rises after edge 33, busy_o high for edges 1..33.
- Signed: −3 × 7 -> 0xFFFFFFFFFFFFFFEB. Then 0x80000000 × 0x00000001 with signed_i=1 -> 0xFFFFFFFF80000000; same operands with signed_i=0 -> 0x0000000080000000. Also 0x80000000 × 0x80000000 signed -> 0x4000000000000000.
- Early-out:
  - 0 × 0x1234 -> ready_o after edge 0, result_o=0.
  - 5 × 3 (STEP=1, EARLY_OUT=1) -> ready_o after edge 3, result_o=15.
  - opa_i changed during RUN -> result unaffected.
- Cancel and reset:
  - cancel_i pulsed at RUN edge 10 -> next edge IDLE, ready_o=0, busy_o=0; a new start then completes with the correct product.
  - rst=0 mid-RUN -> all outputs 0 at that edge.
- Handshake: start_i held high 5 cycles in DONE -> ready_o and result_o stable; drop start_i -> both 0 after next edge.
- Parameter sweep: WIDTH=16, STEP=4, both EARLY_OUT values, 1000 random signed/unsigned pairs -> match reference model and the latency formula exactly.
